hwpe_sel_ctrl: RTL and testbench

Sequencer that owns the HWPE selection and clock-enable controls in the cluster HWPE subsystem. It accepts selection requests from the cluster control registers and drives `hwpe_en_o` / `hwpe_sel_o` into the HWPE subsystem. It switches only after the active HWPE is idle and all TCDM and config transactions have drained, then holds the HWPE clock off for a settle gap. It also blocks the config bus during a switch.

---
 rtl/hwpe_sel_ctrl.sv | 151 +++++++++++++++
 tb/tb_hwpe_sel_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_sel_ctrl.sv
// hwpe_sel_ctrl: sequences HWPE selection/clock-enable switches behind idle and drain checks.
// Latency: OFF accept -> GAP next cycle; GAP lasts GAP_CYCLES; DRAIN exits the cycle after drained.
// Backpressure: req_ready is low in DRAIN/GAP; cfg_block is raised for the whole switch.
module hwpe_sel_ctrl #(
  parameter int N_HWPES         = 2,
  parameter int SEL_W           = (N_HWPES > 1) ? $clog2(N_HWPES) : 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int GAP_CYCLES      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [SEL_W-1:0] req_sel_i,
  input  logic             req_en_i,
  output logic             req_ready_o,
  input  logic             hwpe_busy_i,
  input  logic             tcdm_req_i,
  input  logic             tcdm_gnt_i,
  input  logic             tcdm_r_valid_i,
  input  logic             cfg_req_i,
  input  logic             cfg_gnt_i,
  input  logic             cfg_r_valid_i,
  output logic             cfg_block_o,
  output logic             hwpe_en_o,
  output logic [SEL_W-1:0] hwpe_sel_o,
  output logic [1:0]       state_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W:0]   N_SEL    = (SEL_W + 1)'(N_HWPES);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   pend_sel;
  logic               pend_en;
  logic               load_pend;
  logic               en_q, en_d;
  logic               blk_q, blk_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   tcdm_cnt, cfg_cnt;
  logic [CNT_W:0]     tcdm_nxt, cfg_nxt;

  logic accept, sel_ok, same_target, drained, gap_done;

  // Saturating outstanding counter step; MSB of the result flags an over/underflow.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) r = {1'b1, cnt};
      else                r = {1'b0, cnt + 1'b1};
    end else if (dec && !inc) begin
      if (cnt == '0) r = {1'b1, cnt};
      else           r = {1'b0, cnt - 1'b1};
    end
    return r;
  endfunction

  assign tcdm_nxt = cnt_step(tcdm_cnt, tcdm_req_i && tcdm_gnt_i, tcdm_r_valid_i);
  assign cfg_nxt  = cnt_step(cfg_cnt, cfg_req_i && cfg_gnt_i, cfg_r_valid_i);

  assign req_ready_o = (state_q == ST_OFF) || (state_q == ST_ON);
  assign accept      = req_valid_i && req_ready_o;
  assign sel_ok      = {1'b0, req_sel_i} < N_SEL;
  assign same_target = (req_sel_i == sel_q) && req_en_i;
  // A request rising in the same cycle busy drops still counts as traffic.
  assign drained     = !hwpe_busy_i && (tcdm_cnt == '0) && (cfg_cnt == '0)
                       && !tcdm_req_i && !cfg_req_i;
  assign gap_done    = (gap_cnt == '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_OFF;
    else       state_q <= state_d;
  end

  // Next-state decode; out-of-range selections never move the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (accept && sel_ok && req_en_i) state_d = ST_GAP;
      ST_ON:    if (accept && sel_ok && !same_target) state_d = ST_DRAIN;
      ST_DRAIN: if (drained) state_d = ST_GAP;
      ST_GAP:   if (gap_done) state_d = pend_en ? ST_ON : ST_OFF;
      default:  state_d = ST_OFF;
    endcase
  end

  // Output decode: next values of the registered controls.
  always_comb begin
    en_d      = (state_d == ST_ON) || (state_d == ST_DRAIN);
    blk_d     = (state_d == ST_DRAIN) || (state_d == ST_GAP);
    sel_d     = sel_q;
    load_pend = 1'b0;
    if (state_q == ST_OFF && accept && sel_ok) begin
      sel_d     = req_sel_i;
      load_pend = 1'b1;
    end
    if (state_q == ST_ON && accept && sel_ok && !same_target) load_pend = 1'b1;
    if (state_q == ST_DRAIN && drained) sel_d = pend_sel;
    err_d = err_q || tcdm_nxt[CNT_W] || cfg_nxt[CNT_W] || (accept && !sel_ok);
  end

  // Registered controls, pending target, gap timer and outstanding counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q    <= '0;
      pend_sel <= '0;
      pend_en  <= 1'b0;
      en_q     <= 1'b0;
      blk_q    <= 1'b0;
      err_q    <= 1'b0;
      gap_cnt  <= '0;
      tcdm_cnt <= '0;
      cfg_cnt  <= '0;
    end else begin
      sel_q    <= sel_d;
      en_q     <= en_d;
      blk_q    <= blk_d;
      err_q    <= err_d;
      tcdm_cnt <= tcdm_nxt[CNT_W-1:0];
      cfg_cnt  <= cfg_nxt[CNT_W-1:0];
      if (load_pend) begin
        pend_sel <= req_sel_i;
        pend_en  <= req_en_i;
      end
      if (state_d == ST_GAP && state_q != ST_GAP) gap_cnt <= GAP_LOAD;
      else if (state_q == ST_GAP && !gap_done)   gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign hwpe_en_o   = en_q;
  assign hwpe_sel_o  = sel_q;
  assign cfg_block_o = blk_q;
  assign state_o     = state_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// tb_hwpe_sel_ctrl: directed scenarios plus random traffic against a behavioural model.
// Latency: every cycle compares all DUT outputs to the model one step after the edge.
// Backpressure: request stimulus ignores ready; the model decides acceptance.
module tb_hwpe_sel_ctrl;

  localparam int N   = 3;   // 3 HWPEs so a 2-bit index can express an out-of-range value
  localparam int SW  = 2;
  localparam int MAX = 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [SW-1:0] req_sel;
  logic          req_en;
  logic          req_ready;
  logic          hwpe_busy;
  logic          tcdm_req, tcdm_gnt, tcdm_r_valid;
  logic          cfg_req, cfg_gnt, cfg_r_valid;
  logic          cfg_block, hwpe_en, err;
  logic [SW-1:0] hwpe_sel;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;

  // behavioural model: state codes as listed in the port description
  int m_state, m_sel, m_psel, m_pen, m_tcdm, m_cfg, m_err, m_gap_left;

  hwpe_sel_ctrl #(.N_HWPES(N), .SEL_W(SW), .MAX_OUTSTANDING(MAX), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_sel_i(req_sel), .req_en_i(req_en), .req_ready_o(req_ready),
    .hwpe_busy_i(hwpe_busy),
    .tcdm_req_i(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_r_valid_i(tcdm_r_valid),
    .cfg_req_i(cfg_req), .cfg_gnt_i(cfg_gnt), .cfg_r_valid_i(cfg_r_valid),
    .cfg_block_o(cfg_block), .hwpe_en_o(hwpe_en), .hwpe_sel_o(hwpe_sel),
    .state_o(state), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int count_step(input int c, input bit inc, input bit dec, inout int e);
    if (inc && dec) return c;
    if (inc) begin
      if (c == MAX) begin e = 1; return c; end
      return c + 1;
    end
    if (dec) begin
      if (c == 0) begin e = 1; return 0; end
      return c - 1;
    end
    return c;
  endfunction

  task automatic model_step();
    bit ready, drained;
    int sel;
    if (rst) begin
      m_state = 0; m_sel = 0; m_psel = 0; m_pen = 0;
      m_tcdm = 0; m_cfg = 0; m_err = 0; m_gap_left = 0;
      return;
    end
    ready   = (m_state == 0) || (m_state == 1);
    drained = !hwpe_busy && m_tcdm == 0 && m_cfg == 0 && !tcdm_req && !cfg_req;
    sel     = int'(req_sel);
    m_tcdm  = count_step(m_tcdm, tcdm_req && tcdm_gnt, tcdm_r_valid, m_err);
    m_cfg   = count_step(m_cfg, cfg_req && cfg_gnt, cfg_r_valid, m_err);
    if (req_valid && ready && sel >= N) m_err = 1;
    else begin
      case (m_state)
        0: if (req_valid) begin
             m_sel = sel; m_psel = sel; m_pen = int'(req_en);
             if (req_en) begin m_state = 3; m_gap_left = GAP; end
           end
        1: if (req_valid && !(sel == m_sel && req_en)) begin
             m_psel = sel; m_pen = int'(req_en); m_state = 2;
           end
        2: if (drained) begin m_state = 3; m_sel = m_psel; m_gap_left = GAP; end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_state = m_pen ? 1 : 0;
        end
      endcase
    end
  endtask

  // One clock: advance model on current inputs, clock DUT, compare, clear pulse inputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("state", int'(state), m_state);
    check("sel", int'(hwpe_sel), m_sel);
    check("en", int'(hwpe_en), (m_state == 1 || m_state == 2) ? 1 : 0);
    check("cfg_block", int'(cfg_block), (m_state == 2 || m_state == 3) ? 1 : 0);
    check("ready", int'(req_ready), (m_state <= 1) ? 1 : 0);
    check("err", int'(err), m_err);
    rst = 0; req_valid = 0;
    tcdm_req = 0; tcdm_gnt = 0; tcdm_r_valid = 0;
    cfg_req = 0; cfg_gnt = 0; cfg_r_valid = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input int sel, input bit en);
    req_valid = 1; req_sel = SW'(sel); req_en = en;
    tick();
  endtask

  initial begin
    rst = 1; req_valid = 0; req_sel = '0; req_en = 0; hwpe_busy = 0;
    tcdm_req = 0; tcdm_gnt = 0; tcdm_r_valid = 0;
    cfg_req = 0; cfg_gnt = 0; cfg_r_valid = 0;
    m_state = 0; m_sel = 0; m_psel = 0; m_pen = 0;
    m_tcdm = 0; m_cfg = 0; m_err = 0; m_gap_left = 0;

    // reset state
    rst = 1; tick();
    check("rst_state", int'(state), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_en", int'(hwpe_en), 0);

    // power-on enable: GAP + new sel next cycle, ON after GAP cycles
    ticks(4);
    request(1, 1);
    check("pwr_gap", int'(state), 3);
    check("pwr_sel", int'(hwpe_sel), 1);
    tick();
    check("pwr_gap2", int'(state), 3);
    tick();
    check("pwr_on", int'(state), 1);
    check("pwr_en", int'(hwpe_en), 1);

    // go to sel 0 while idle, then switch to 1 while busy with 3 TCDM outstanding
    request(0, 1);
    ticks(3);
    check("sw0_on", int'(state), 1);
    check("sw0_sel", int'(hwpe_sel), 0);
    hwpe_busy = 1;
    for (int i = 0; i < 3; i++) begin tcdm_req = 1; tcdm_gnt = 1; tick(); end
    request(1, 1);
    for (int i = 0; i < 3; i++) begin
      check("busy_drain", int'(state), 2);
      check("busy_en", int'(hwpe_en), 1);
      check("busy_blk", int'(cfg_block), 1);
      tick();
    end
    hwpe_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tcdm_r_valid = 1; tick();
      check("rv_drain", int'(state), 2);
    end
    tick();
    check("sw_gap", int'(state), 3);
    check("sw_gap_sel", int'(hwpe_sel), 1);
    check("sw_gap_en", int'(hwpe_en), 0);
    ticks(2);
    check("sw_on", int'(state), 1);

    // same-target no-op, then disable with busy dropping as tcdm_req rises
    request(1, 1);
    check("same_state", int'(state), 1);
    check("same_ready", int'(req_ready), 1);
    hwpe_busy = 1;
    request(1, 0);
    check("dis_drain", int'(state), 2);
    hwpe_busy = 0; tcdm_req = 1; tick();
    check("late_req_drain", int'(state), 2);
    tick();
    check("dis_gap", int'(state), 3);
    ticks(2);
    check("dis_off", int'(state), 0);
    check("dis_en", int'(hwpe_en), 0);

    // simultaneous grant+response keeps the count, DRAIN holds until the last response
    request(0, 1);
    ticks(3);
    tcdm_req = 1; tcdm_gnt = 1; tick();
    request(1, 1);
    tcdm_req = 1; tcdm_gnt = 1; tcdm_r_valid = 1; tick();
    tick();
    check("simul_drain", int'(state), 2);
    tcdm_r_valid = 1; tick();
    check("last_rv_drain", int'(state), 2);
    tick();
    check("simul_gap", int'(state), 3);
    ticks(2);

    // saturation: 9 grants without responses
    for (int i = 0; i < MAX; i++) begin cfg_req = 1; cfg_gnt = 1; tick(); end
    check("sat_no_err", int'(err), 0);
    cfg_req = 1; cfg_gnt = 1; tick();
    check("sat_err", int'(err), 1);

    // out-of-range selection from a fresh reset
    rst = 1; tick();
    request(3, 1);
    check("oor_state", int'(state), 0);
    check("oor_sel", int'(hwpe_sel), 0);
    check("oor_err", int'(err), 1);
    ticks(3);
    check("oor_sticky", int'(err), 1);

    // mid-GAP reset
    request(2, 1);
    check("mg_gap", int'(state), 3);
    rst = 1; tick();
    check("mg_state", int'(state), 0);
    check("mg_sel", int'(hwpe_sel), 0);
    check("mg_en", int'(hwpe_en), 0);
    check("mg_blk", int'(cfg_block), 0);
    check("mg_err", int'(err), 0);
    check("mg_ready", int'(req_ready), 1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) hwpe_busy = ~hwpe_busy;
      req_valid = ($urandom_range(0, 5) == 0);
      req_sel   = SW'($urandom_range(0, 3));
      req_en    = 1'($urandom_range(0, 3) != 0);
      tcdm_req  = ($urandom_range(0, 2) == 0);
      tcdm_gnt  = tcdm_req && ($urandom_range(0, 1) == 1);
      tcdm_r_valid = (m_tcdm > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      cfg_req   = ($urandom_range(0, 3) == 0);
      cfg_gnt   = cfg_req && ($urandom_range(0, 1) == 1);
      cfg_r_valid = (m_cfg > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
